sram_axi_slave: RTL and testbench
=================================

SRAM_AXI_SLAVE -- requirements
Module: sram_axi_slave

Interface
REQ-001 The block SHALL have parameter ID_W, default 8, meaning the slave-side AXI ID width.
REQ-002 The block SHALL have parameter IDX_W, default 14, meaning the SRAM word-index width (64 KiB).
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
  ACLK  in  1  single clock, all logic on rising edge
  ARESETn  in  1  synchronous, active-low reset
  ARID_S/ARADDR_S/ARLEN_S/ARSIZE_S/ARBURST_S/ARVALID_S  in  ID_W/32/4/3/2/1  read address channel
  ARREADY_S  out  1  read address accept
  RID_S/RDATA_S/RRESP_S/RLAST_S/RVALID_S  out  ID_W/32/2/1/1  read data channel
  RREADY_S  in  1  read data accept
  AWID_S/AWADDR_S/AWLEN_S/AWSIZE_S/AWBURST_S/AWVALID_S  in  ID_W/32/4/3/2/1  write address channel
  AWREADY_S  out  1  write address accept
  WDATA_S/WSTRB_S/WLAST_S/WVALID_S  in  32/4/1/1  write data channel
  WREADY_S  out  1  write data accept
  BID_S/BRESP_S/BVALID_S  out  ID_W/2/1  write response channel
  BREADY_S  in  1  write response accept
  CEB  out  1  SRAM chip enable, active low
  WEB  out  4  SRAM byte write enable, active low (4'b1111 = no write)
  A  out  IDX_W  SRAM word index
  DI  out  32  SRAM write data
  DO  in  32  SRAM read data, valid one cycle after a CEB=0 read

Function
REQ-004 The block SHALL implement FSM states IDLE, RD_FETCH, RD_DATA, WR_DATA, WR_RESP.
REQ-005 In IDLE, AWREADY_S SHALL be 1 and ARREADY_S SHALL be (!AWVALID_S); all other states drive both low.
REQ-006 Simultaneous AWVALID_S and ARVALID_S in IDLE SHALL grant write; read accepted no earlier than the cycle after return to IDLE.
REQ-007 On AR handshake the block SHALL latch ID, ADDR, LEN, BURST, clear beat counter, go RD_FETCH.
REQ-008 RD_FETCH SHALL last one cycle with CEB=0, WEB=4'b1111, A=addr[IDX_W+1:2], then go RD_DATA.
REQ-009 On entry to RD_DATA the block SHALL capture DO into a data register; RDATA_S SHALL come from that register and stay stable while RVALID_S=1 and RREADY_S=0.
REQ-010 RD_DATA SHALL drive RVALID_S=1, RID_S=latched ID, RRESP_S=2'b00, RLAST_S=(beat==LEN).
REQ-011 On R handshake with RLAST_S=0: beat+1, addr+4 for INCR (unchanged for FIXED), go RD_FETCH; with RLAST_S=1 go IDLE.
REQ-012 Read latency SHALL be: AR handshake at cycle T, first RVALID_S at T+2; each later beat 2 cycles after previous R handshake.
REQ-013 On AW handshake the block SHALL latch ID, ADDR, BURST, go WR_DATA.
REQ-014 WR_DATA SHALL drive WREADY_S=1; on W handshake CEB=0, WEB=~WSTRB_S, DI=WDATA_S, A=latched index, same cycle (combinational).
REQ-015 After a W handshake with WLAST_S=0 the address SHALL advance as in REQ-011; with WLAST_S=1 go WR_RESP.
REQ-016 WR_RESP SHALL drive BVALID_S=1, BID_S=latched ID, BRESP_S=2'b00; on BREADY_S go IDLE.
REQ-017 WSTRB_S=4'b0000 SHALL still complete the beat with WEB=4'b1111.
REQ-018 Index SHALL wrap modulo 2^IDX_W; ADDR bits above IDX_W+1 and [1:0] ignored.
REQ-019 ARSIZE_S/AWSIZE_S SHALL be ignored (word access); responses always OKAY.
REQ-020 Outside REQ-008/REQ-014 cycles CEB SHALL be 1, WEB 4'b1111.

Reset
REQ-021 With ARESETn=0 at a clock edge, FSM SHALL go IDLE; all VALID/READY outputs 0 during reset; CEB=1, WEB=4'b1111, A=0, DI=0, RDATA_S=0, RID_S/BID_S=0, RLAST_S=0.
REQ-022 Reset mid-burst SHALL discard the transaction; no further R/B beats for it.

Structure
REQ-023 Shared package axi_pkg SHALL hold AXI widths, burst codes (FIXED=2'b00, INCR=2'b01), response codes and the state enum.
REQ-024 The block SHALL be one module with no sub-modules; SRAM macro instantiated by parent.

Verification
REQ-025 AR ID=0x11, ADDR=0x0000_0010, LEN=3, INCR, RREADY_S=1, SRAM preloaded idx4..7=0xA0..0xA3 -> four beats 0xA0..0xA3, RLAST_S on 4th only, first RVALID_S at T+2.
REQ-026 AW ADDR=0x20, WDATA=0xDEADBEEF, WSTRB=4'b0011, WLAST=1 -> WEB=4'b1100, A=8 on W handshake; BVALID_S next cycle, BID=AWID, BRESP=0.
REQ-027 AWVALID_S and ARVALID_S both raised in IDLE -> write completes first, ARREADY_S=0 until write returns IDLE.
REQ-028 Read LEN=1, RREADY_S held 0 for 5 cycles on beat 0 -> RDATA_S/RID_S/RLAST_S stable, no SRAM access.
REQ-029 Read ADDR=0x0000_FFFC, LEN=1, INCR -> A=0x3FFF then 0x0000.
REQ-030 ARESETn=0 during beat 2 of LEN=3 read -> RVALID_S=0 next cycle, IDLE, new AR accepted after release.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI definitions for the SRAM slave: channel widths, burst and
// response encodings, and the slave FSM state type.
package axi_pkg;

   localparam int AXI_ADDR_W  = 32;
   localparam int AXI_DATA_W  = 32;
   localparam int AXI_STRB_W  = AXI_DATA_W / 8;
   localparam int AXI_LEN_W   = 4;
   localparam int AXI_SIZE_W  = 3;
   localparam int AXI_BURST_W = 2;
   localparam int AXI_RESP_W  = 2;

   localparam logic [AXI_BURST_W-1:0] BURST_FIXED = 2'b00;
   localparam logic [AXI_BURST_W-1:0] BURST_INCR  = 2'b01;
   localparam logic [AXI_BURST_W-1:0] BURST_WRAP  = 2'b10;

   localparam logic [AXI_RESP_W-1:0] RESP_OKAY   = 2'b00;
   localparam logic [AXI_RESP_W-1:0] RESP_EXOKAY = 2'b01;
   localparam logic [AXI_RESP_W-1:0] RESP_SLVERR = 2'b10;
   localparam logic [AXI_RESP_W-1:0] RESP_DECERR = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RD_FETCH = 3'd1,
      ST_RD_DATA  = 3'd2,
      ST_WR_DATA  = 3'd3,
      ST_WR_RESP  = 3'd4
   } state_t;

endpackage

// File: rtl/sram_axi_slave.sv
// AXI3-style slave in front of a single-port synchronous SRAM (32-bit words,
// one-cycle read latency). One transaction at a time; writes win ties.
module sram_axi_slave
   import axi_pkg::*;
#(
   parameter int ID_W  = 8,
   parameter int IDX_W = 14
) (
   input  logic                   ACLK,
   input  logic                   ARESETn,
   input  logic [ID_W-1:0]        ARID_S,
   input  logic [AXI_ADDR_W-1:0]  ARADDR_S,
   input  logic [AXI_LEN_W-1:0]   ARLEN_S,
   input  logic [AXI_SIZE_W-1:0]  ARSIZE_S,
   input  logic [AXI_BURST_W-1:0] ARBURST_S,
   input  logic                   ARVALID_S,
   output logic                   ARREADY_S,
   output logic [ID_W-1:0]        RID_S,
   output logic [AXI_DATA_W-1:0]  RDATA_S,
   output logic [AXI_RESP_W-1:0]  RRESP_S,
   output logic                   RLAST_S,
   output logic                   RVALID_S,
   input  logic                   RREADY_S,
   input  logic [ID_W-1:0]        AWID_S,
   input  logic [AXI_ADDR_W-1:0]  AWADDR_S,
   input  logic [AXI_LEN_W-1:0]   AWLEN_S,
   input  logic [AXI_SIZE_W-1:0]  AWSIZE_S,
   input  logic [AXI_BURST_W-1:0] AWBURST_S,
   input  logic                   AWVALID_S,
   output logic                   AWREADY_S,
   input  logic [AXI_DATA_W-1:0]  WDATA_S,
   input  logic [AXI_STRB_W-1:0]  WSTRB_S,
   input  logic                   WLAST_S,
   input  logic                   WVALID_S,
   output logic                   WREADY_S,
   output logic [ID_W-1:0]        BID_S,
   output logic [AXI_RESP_W-1:0]  BRESP_S,
   output logic                   BVALID_S,
   input  logic                   BREADY_S,
   output logic                   CEB,
   output logic [AXI_STRB_W-1:0]  WEB,
   output logic [IDX_W-1:0]       A,
   output logic [AXI_DATA_W-1:0]  DI,
   input  logic [AXI_DATA_W-1:0]  DO
);

   state_t                 state_reg, state_next;
   logic [ID_W-1:0]        id_reg;
   logic [IDX_W-1:0]       idx_reg;
   logic [AXI_LEN_W-1:0]   len_reg;
   logic [AXI_LEN_W-1:0]   beat_reg;
   logic [AXI_BURST_W-1:0] burst_reg;
   logic [AXI_DATA_W-1:0]  rdata_reg;
   logic                   fresh_reg;

   logic                   run;
   logic                   rd_last;
   logic                   w_hs;
   logic                   fetch;
   logic [IDX_W-1:0]       idx_adv;
   logic                   unused_bits;

   // Size, AWLEN (WLAST ends the burst) and out-of-window address bits are don't-care.
   assign unused_bits = ^{ARSIZE_S, AWSIZE_S, AWLEN_S,
                          ARADDR_S[AXI_ADDR_W-1:IDX_W+2], ARADDR_S[1:0],
                          AWADDR_S[AXI_ADDR_W-1:IDX_W+2], AWADDR_S[1:0]};

   assign run     = ARESETn;
   assign rd_last = (beat_reg == len_reg);
   assign idx_adv = (burst_reg == BURST_FIXED) ? idx_reg
                                               : idx_reg + {{(IDX_W-1){1'b0}}, 1'b1};

   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         ST_IDLE: begin
            if (AWVALID_S)      state_next = ST_WR_DATA;
            else if (ARVALID_S) state_next = ST_RD_FETCH;
         end
         ST_RD_FETCH: state_next = ST_RD_DATA;
         ST_RD_DATA:  if (RREADY_S) state_next = rd_last ? ST_IDLE : ST_RD_FETCH;
         ST_WR_DATA:  if (WVALID_S && WLAST_S) state_next = ST_WR_RESP;
         ST_WR_RESP:  if (BREADY_S) state_next = ST_IDLE;
         default:     state_next = ST_IDLE;
      endcase
   end

   assign AWREADY_S = run && (state_reg == ST_IDLE);
   assign ARREADY_S = run && (state_reg == ST_IDLE) && !AWVALID_S;
   assign RVALID_S  = run && (state_reg == ST_RD_DATA);
   assign WREADY_S  = run && (state_reg == ST_WR_DATA);
   assign BVALID_S  = run && (state_reg == ST_WR_RESP);

   // SRAM DO is only valid in the first RD_DATA cycle, so pass it straight
   // through then and serve the captured copy while the master stalls.
   assign RDATA_S = !run ? '0 : (fresh_reg ? DO : rdata_reg);
   assign RID_S   = run ? id_reg : '0;
   assign RRESP_S = RESP_OKAY;
   assign RLAST_S = RVALID_S && rd_last;
   assign BID_S   = run ? id_reg : '0;
   assign BRESP_S = RESP_OKAY;

   assign w_hs  = WREADY_S && WVALID_S;
   assign fetch = run && (state_reg == ST_RD_FETCH);
   assign CEB   = !(fetch || w_hs);
   assign WEB   = w_hs ? ~WSTRB_S : {AXI_STRB_W{1'b1}};
   assign A     = run ? idx_reg : '0;
   assign DI    = w_hs ? WDATA_S : '0;

   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         state_reg <= ST_IDLE;
         id_reg    <= '0;
         idx_reg   <= '0;
         len_reg   <= '0;
         beat_reg  <= '0;
         burst_reg <= BURST_FIXED;
         rdata_reg <= '0;
         fresh_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         fresh_reg <= (state_reg == ST_RD_FETCH);
         if (fresh_reg) rdata_reg <= DO;
         unique case (state_reg)
            ST_IDLE: begin
               if (AWVALID_S) begin
                  id_reg    <= AWID_S;
                  idx_reg   <= AWADDR_S[IDX_W+1:2];
                  burst_reg <= AWBURST_S;
               end else if (ARVALID_S) begin
                  id_reg    <= ARID_S;
                  idx_reg   <= ARADDR_S[IDX_W+1:2];
                  len_reg   <= ARLEN_S;
                  burst_reg <= ARBURST_S;
                  beat_reg  <= '0;
               end
            end
            ST_RD_DATA: begin
               if (RREADY_S && !rd_last) begin
                  beat_reg <= beat_reg + 4'd1;
                  idx_reg  <= idx_adv;
               end
            end
            ST_WR_DATA: begin
               if (WVALID_S && !WLAST_S) idx_reg <= idx_adv;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_axi_slave.sv
// Self-checking bench for sram_axi_slave with a behavioural one-cycle SRAM
// and a scoreboard of expected read beats and SRAM fetch indices.
module tb_sram_axi_slave;

   localparam int ID_W  = 8;
   localparam int IDX_W = 14;

   logic              ACLK = 1'b0;
   logic              ARESETn = 1'b0;
   logic [ID_W-1:0]   ARID_S, RID_S, AWID_S, BID_S;
   logic [31:0]       ARADDR_S, AWADDR_S, RDATA_S, WDATA_S, DI, DO;
   logic [3:0]        ARLEN_S, AWLEN_S, WSTRB_S, WEB;
   logic [2:0]        ARSIZE_S, AWSIZE_S;
   logic [1:0]        ARBURST_S, AWBURST_S, RRESP_S, BRESP_S;
   logic              ARVALID_S, ARREADY_S, RLAST_S, RVALID_S, RREADY_S;
   logic              AWVALID_S, AWREADY_S, WLAST_S, WVALID_S, WREADY_S;
   logic              BVALID_S, BREADY_S, CEB;
   logic [IDX_W-1:0]  A;

   typedef struct packed {
      logic [ID_W-1:0] id;
      logic [31:0]     data;
      logic            last;
   } rbeat_t;

   rbeat_t           exp_r[$];
   logic [IDX_W-1:0] exp_a[$];
   logic [31:0]      mem [0:(1<<IDX_W)-1];
   int               total = 0;
   int               bad = 0;

   always #5 ACLK = ~ACLK;

   // Behavioural SRAM: registered read, per-byte active-low write enables.
   always @(posedge ACLK) begin
      if (!CEB) begin
         if (WEB == 4'hF) DO <= mem[A];
         else for (int b = 0; b < 4; b++)
            if (!WEB[b]) mem[A][8*b +: 8] <= DI[8*b +: 8];
      end
   end

   sram_axi_slave #(.ID_W(ID_W), .IDX_W(IDX_W)) dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S), .ARSIZE_S(ARSIZE_S),
      .ARBURST_S(ARBURST_S), .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
      .RID_S(RID_S), .RDATA_S(RDATA_S), .RRESP_S(RRESP_S), .RLAST_S(RLAST_S),
      .RVALID_S(RVALID_S), .RREADY_S(RREADY_S),
      .AWID_S(AWID_S), .AWADDR_S(AWADDR_S), .AWLEN_S(AWLEN_S), .AWSIZE_S(AWSIZE_S),
      .AWBURST_S(AWBURST_S), .AWVALID_S(AWVALID_S), .AWREADY_S(AWREADY_S),
      .WDATA_S(WDATA_S), .WSTRB_S(WSTRB_S), .WLAST_S(WLAST_S), .WVALID_S(WVALID_S),
      .WREADY_S(WREADY_S), .BID_S(BID_S), .BRESP_S(BRESP_S), .BVALID_S(BVALID_S),
      .BREADY_S(BREADY_S), .CEB(CEB), .WEB(WEB), .A(A), .DI(DI), .DO(DO)
   );

   task automatic drive_ar(input logic [7:0] id, input logic [31:0] addr,
                           input logic [3:0] len, input logic [1:0] burst);
      ARVALID_S = 1'b1; ARID_S = id; ARADDR_S = addr; ARLEN_S = len;
      ARBURST_S = burst; ARSIZE_S = 3'd2;
   endtask

   // Scoreboard consumer: pops expected fetch indices and R beats as they appear.
   task automatic drain_reads(input int max_cyc, output int first_rv);
      int k = 0;
      rbeat_t e;
      logic [IDX_W-1:0] ea;
      first_rv = -1;
      while ((exp_r.size() > 0 || exp_a.size() > 0) && k < max_cyc) begin
         @(negedge ACLK); ARVALID_S = 1'b0; #1; k++;
         if (!CEB && WEB == 4'hF) begin
            total++;
            if (exp_a.size() == 0) begin
               bad++; $display("FAIL fetch_extra got A=%h want no access", A);
            end else begin
               ea = exp_a.pop_front();
               if (A !== ea) begin bad++; $display("FAIL fetch_index got=%h want=%h", A, ea); end
            end
         end
         if (RVALID_S && first_rv < 0) first_rv = k;
         if (RVALID_S && RREADY_S) begin
            total++;
            if (exp_r.size() == 0) begin
               bad++; $display("FAIL r_extra got data=%h", RDATA_S);
            end else begin
               e = exp_r.pop_front();
               if ({RID_S, RDATA_S, RLAST_S, RRESP_S} !== {e.id, e.data, e.last, 2'b00}) begin
                  bad++;
                  $display("FAIL r_beat got id=%h data=%h last=%b resp=%b want id=%h data=%h last=%b resp=00",
                           RID_S, RDATA_S, RLAST_S, RRESP_S, e.id, e.data, e.last);
               end else $display("r beat id=%h data=%h last=%b", RID_S, RDATA_S, RLAST_S);
            end
         end
      end
      total++;
      if (exp_r.size() != 0 || exp_a.size() != 0) begin
         bad++;
         $display("FAIL drain_timeout got pending r=%0d a=%0d want 0", exp_r.size(), exp_a.size());
      end
      exp_r.delete(); exp_a.delete();
   endtask

   task automatic test_reset();
      ARESETn = 1'b0;
      repeat (2) @(negedge ACLK);
      #1;
      total++;
      if ({ARREADY_S, AWREADY_S, WREADY_S, RVALID_S, BVALID_S} !== 5'b0) begin
         bad++; $display("FAIL reset_handshake got=%b want=00000",
                         {ARREADY_S, AWREADY_S, WREADY_S, RVALID_S, BVALID_S});
      end
      total++;
      if ({CEB, WEB} !== 5'b11111) begin bad++; $display("FAIL reset_sram_ctl got=%b want=11111", {CEB, WEB}); end
      total++;
      if ({A, DI, RDATA_S, RID_S, BID_S, RLAST_S} !== '0) begin
         bad++; $display("FAIL reset_data got A=%h DI=%h RDATA=%h RID=%h BID=%h RLAST=%b want 0",
                         A, DI, RDATA_S, RID_S, BID_S, RLAST_S);
      end
      @(negedge ACLK); ARESETn = 1'b1; #1;
      total++;
      if ({AWREADY_S, ARREADY_S} !== 2'b11) begin
         bad++; $display("FAIL idle_ready got=%b want=11", {AWREADY_S, ARREADY_S});
      end
      $display("reset checked");
   endtask

   task automatic test_read_incr();
      int first_rv;
      for (int i = 0; i < 4; i++) begin
         mem[4+i] = 32'hA0 + i;
         exp_a.push_back(IDX_W'(4 + i));
         exp_r.push_back('{id: 8'h11, data: 32'hA0 + i, last: (i == 3)});
      end
      @(negedge ACLK); drive_ar(8'h11, 32'h10, 4'd3, 2'b01); RREADY_S = 1'b1; #1;
      total++;
      if (ARREADY_S !== 1'b1) begin bad++; $display("FAIL incr_arready got=%b want=1", ARREADY_S); end
      drain_reads(40, first_rv);
      total++;
      if (first_rv !== 2) begin bad++; $display("FAIL incr_latency got=%0d want=2", first_rv); end
   endtask

   task automatic test_read_fixed();
      int first_rv;
      for (int i = 0; i < 3; i++) begin
         exp_a.push_back(IDX_W'(12));
         exp_r.push_back('{id: 8'h2F, data: 32'h0C0C0C0C, last: (i == 2)});
      end
      mem[12] = 32'h0C0C0C0C;
      @(negedge ACLK); drive_ar(8'h2F, 32'h30, 4'd2, 2'b00); RREADY_S = 1'b1;
      drain_reads(40, first_rv);
   endtask

   task automatic test_read_wrap();
      int first_rv;
      mem[14'h3FFF] = 32'h11112222;
      mem[0]        = 32'h33334444;
      exp_a.push_back(14'h3FFF); exp_a.push_back(14'h0000);
      exp_r.push_back('{id: 8'h7E, data: 32'h11112222, last: 1'b0});
      exp_r.push_back('{id: 8'h7E, data: 32'h33334444, last: 1'b1});
      @(negedge ACLK); drive_ar(8'h7E, 32'h0000_FFFC, 4'd1, 2'b01); RREADY_S = 1'b1;
      drain_reads(40, first_rv);
   endtask

   task automatic test_read_stall();
      int k = 0;
      int first_rv;
      mem[16] = 32'h5A5A0001;
      mem[17] = 32'h5A5A0002;
      @(negedge ACLK); drive_ar(8'h22, 32'h40, 4'd1, 2'b01); RREADY_S = 1'b0; #1;
      do begin @(negedge ACLK); ARVALID_S = 1'b0; #1; k++; end while (!RVALID_S && k < 10);
      total++;
      if (RVALID_S !== 1'b1) begin bad++; $display("FAIL stall_rvalid got=%b want=1", RVALID_S); end
      for (int i = 0; i < 5; i++) begin
         total++;
         if ({RDATA_S, RID_S, RLAST_S, CEB} !== {32'h5A5A0001, 8'h22, 1'b0, 1'b1}) begin
            bad++; $display("FAIL stall_hold cyc=%0d got data=%h id=%h last=%b ceb=%b want 5a5a0001 22 0 1",
                            i, RDATA_S, RID_S, RLAST_S, CEB);
         end
         @(negedge ACLK); #1;
      end
      RREADY_S = 1'b1; #1;
      total++;
      if ({RVALID_S, RDATA_S} !== {1'b1, 32'h5A5A0001}) begin
         bad++; $display("FAIL stall_release got valid=%b data=%h want 1 5a5a0001", RVALID_S, RDATA_S);
      end
      exp_a.push_back(IDX_W'(17));
      exp_r.push_back('{id: 8'h22, data: 32'h5A5A0002, last: 1'b1});
      drain_reads(20, first_rv);
      total++;
      if (first_rv !== 2) begin bad++; $display("FAIL stall_next_latency got=%0d want=2", first_rv); end
   endtask

   task automatic test_write();
      logic [31:0] bdata;
      mem[8] = 32'h0;
      @(negedge ACLK);
      AWVALID_S = 1'b1; AWID_S = 8'h5C; AWADDR_S = 32'h20; AWLEN_S = 4'd0;
      AWBURST_S = 2'b01; AWSIZE_S = 3'd2; BREADY_S = 1'b0; #1;
      total++;
      if (AWREADY_S !== 1'b1) begin bad++; $display("FAIL wr_awready got=%b want=1", AWREADY_S); end
      @(negedge ACLK);
      AWVALID_S = 1'b0; WVALID_S = 1'b1; WDATA_S = 32'hDEADBEEF; WSTRB_S = 4'b0011; WLAST_S = 1'b1; #1;
      total++;
      if ({WREADY_S, CEB, WEB, A, DI} !== {1'b1, 1'b0, 4'b1100, 14'd8, 32'hDEADBEEF}) begin
         bad++; $display("FAIL wr_sram got wready=%b ceb=%b web=%b A=%h DI=%h want 1 0 1100 0008 deadbeef",
                         WREADY_S, CEB, WEB, A, DI);
      end
      @(negedge ACLK); WVALID_S = 1'b0; #1;
      total++;
      if ({BVALID_S, BID_S, BRESP_S, CEB} !== {1'b1, 8'h5C, 2'b00, 1'b1}) begin
         bad++; $display("FAIL wr_bresp got bvalid=%b bid=%h bresp=%b ceb=%b want 1 5c 00 1",
                         BVALID_S, BID_S, BRESP_S, CEB);
      end
      BREADY_S = 1'b1;
      @(negedge ACLK); BREADY_S = 1'b0; #1;
      total++;
      if ({BVALID_S, AWREADY_S} !== 2'b01) begin
         bad++; $display("FAIL wr_return got bvalid=%b awready=%b want 0 1", BVALID_S, AWREADY_S);
      end
      bdata = mem[8];
      total++;
      if (bdata !== 32'h0000BEEF) begin bad++; $display("FAIL wr_mem got=%h want=0000beef", bdata); end
      $display("write id=5c addr=20 mem=%h", bdata);
   endtask

   task automatic test_write_burst_strb();
      logic [31:0] wd [3] = '{32'h01020304, 32'h99999999, 32'hAB000000};
      logic [3:0]  ws [3] = '{4'hF, 4'h0, 4'b1000};
      logic [31:0] want [3] = '{32'h01020304, 32'h77777777, 32'hAB111111};
      logic [31:0] got;
      mem[20] = 32'h0; mem[21] = 32'h77777777; mem[22] = 32'h11111111;
      @(negedge ACLK);
      AWVALID_S = 1'b1; AWID_S = 8'h3A; AWADDR_S = 32'h50; AWLEN_S = 4'd2; AWBURST_S = 2'b01;
      BREADY_S = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge ACLK);
         AWVALID_S = 1'b0; WVALID_S = 1'b1; WDATA_S = wd[i]; WSTRB_S = ws[i]; WLAST_S = (i == 2); #1;
         total++;
         if ({CEB, WEB, A} !== {1'b0, ~ws[i], IDX_W'(20 + i)}) begin
            bad++; $display("FAIL wrb_beat%0d got ceb=%b web=%b A=%h want 0 %b %h",
                            i, CEB, WEB, A, ~ws[i], 20 + i);
         end
      end
      @(negedge ACLK); WVALID_S = 1'b0; #1;
      total++;
      if ({BVALID_S, BID_S} !== {1'b1, 8'h3A}) begin
         bad++; $display("FAIL wrb_bresp got bvalid=%b bid=%h want 1 3a", BVALID_S, BID_S);
      end
      @(negedge ACLK); BREADY_S = 1'b0;
      for (int i = 0; i < 3; i++) begin
         got = mem[20+i];
         total++;
         if (got !== want[i]) begin bad++; $display("FAIL wrb_mem%0d got=%h want=%h", i, got, want[i]); end
      end
      $display("write burst id=3a done");
   endtask

   task automatic test_collision();
      int first_rv;
      logic [31:0] got;
      @(negedge ACLK);
      drive_ar(8'h33, 32'h10, 4'd0, 2'b01);
      AWVALID_S = 1'b1; AWID_S = 8'h44; AWADDR_S = 32'h60; AWBURST_S = 2'b01; #1;
      total++;
      if ({AWREADY_S, ARREADY_S} !== 2'b10) begin
         bad++; $display("FAIL col_grant got aw=%b ar=%b want 1 0", AWREADY_S, ARREADY_S);
      end
      @(negedge ACLK);
      AWVALID_S = 1'b0; WVALID_S = 1'b1; WDATA_S = 32'hCAFE0000; WSTRB_S = 4'hF; WLAST_S = 1'b1; #1;
      total++;
      if (ARREADY_S !== 1'b0) begin bad++; $display("FAIL col_ar_wdata got=%b want=0", ARREADY_S); end
      @(negedge ACLK); WVALID_S = 1'b0; BREADY_S = 1'b1; #1;
      total++;
      if ({ARREADY_S, BVALID_S} !== 2'b01) begin
         bad++; $display("FAIL col_ar_wresp got ar=%b bvalid=%b want 0 1", ARREADY_S, BVALID_S);
      end
      @(negedge ACLK); BREADY_S = 1'b0; RREADY_S = 1'b1; #1;
      total++;
      if (ARREADY_S !== 1'b1) begin bad++; $display("FAIL col_ar_idle got=%b want=1", ARREADY_S); end
      exp_a.push_back(IDX_W'(4));
      exp_r.push_back('{id: 8'h33, data: 32'hA0, last: 1'b1});
      drain_reads(20, first_rv);
      got = mem[24];
      total++;
      if (got !== 32'hCAFE0000) begin bad++; $display("FAIL col_mem got=%h want=cafe0000", got); end
   endtask

   task automatic test_reset_mid_burst();
      int k = 0;
      int nb = 0;
      int first_rv;
      logic hit = 1'b0;
      @(negedge ACLK); drive_ar(8'h55, 32'h10, 4'd3, 2'b01); RREADY_S = 1'b1;
      while (!hit && k < 30) begin
         @(negedge ACLK); ARVALID_S = 1'b0; #1; k++;
         if (RVALID_S) begin
            if (nb == 2) begin hit = 1'b1; ARESETn = 1'b0; RREADY_S = 1'b0; end
            nb++;
         end
      end
      total++;
      if (!hit) begin bad++; $display("FAIL rst_find_beat2 got beats=%0d want 3", nb); end
      @(negedge ACLK); #1;
      total++;
      if ({RVALID_S, CEB, ARREADY_S} !== 3'b010) begin
         bad++; $display("FAIL rst_mid got rvalid=%b ceb=%b arready=%b want 0 1 0", RVALID_S, CEB, ARREADY_S);
      end
      ARESETn = 1'b1; RREADY_S = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge ACLK); #1;
         total++;
         if ({RVALID_S, CEB} !== 2'b01) begin
            bad++; $display("FAIL rst_quiet cyc=%0d got rvalid=%b ceb=%b want 0 1", i, RVALID_S, CEB);
         end
      end
      @(negedge ACLK); drive_ar(8'h66, 32'h14, 4'd0, 2'b01); #1;
      total++;
      if (ARREADY_S !== 1'b1) begin bad++; $display("FAIL rst_new_ar got=%b want=1", ARREADY_S); end
      exp_a.push_back(IDX_W'(5));
      exp_r.push_back('{id: 8'h66, data: 32'hA1, last: 1'b1});
      drain_reads(20, first_rv);
   endtask

   initial begin
      ARID_S = '0; ARADDR_S = '0; ARLEN_S = '0; ARSIZE_S = '0; ARBURST_S = '0; ARVALID_S = 1'b0;
      RREADY_S = 1'b0; AWID_S = '0; AWADDR_S = '0; AWLEN_S = '0; AWSIZE_S = '0; AWBURST_S = '0;
      AWVALID_S = 1'b0; WDATA_S = '0; WSTRB_S = '0; WLAST_S = 1'b0; WVALID_S = 1'b0; BREADY_S = 1'b0;
      test_reset();
      test_read_incr();
      test_read_fixed();
      test_read_wrap();
      test_read_stall();
      test_write();
      test_write_burst_strb();
      test_collision();
      test_reset_mid_burst();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
